delta_frame_filter: RTL



---
 rtl/delta_pkg.sv | 8 +
 rtl/delta_avg_window.sv | 40 ++++
 rtl/delta_frame_filter.sv | 99 +++++++++
 3 files changed

// File: rtl/delta_pkg.sv
// Shared definitions for the delta-frame filter: mode bit positions and default sample width.
package delta_pkg;

  localparam int MODE_AVG_BIT        = 0;
  localparam int MODE_HYST_BIT       = 1;
  localparam int DEFAULT_COLOR_WIDTH = 10;

endpackage

// File: rtl/delta_avg_window.sv
// Power-of-two moving-average window: circular buffer of recent differences plus a running sum.
module delta_avg_window #(
  parameter int COLOR_WIDTH         = 10,
  parameter int FILTER_LENGTH       = 16,
  parameter int CLOG2_FILTER_LENGTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [COLOR_WIDTH-1:0] diff,
  output logic [COLOR_WIDTH-1:0] avg
);

  localparam int SUM_WIDTH = COLOR_WIDTH + CLOG2_FILTER_LENGTH;
  localparam logic [CLOG2_FILTER_LENGTH-1:0] LAST_SLOT = CLOG2_FILTER_LENGTH'(FILTER_LENGTH - 1);

  logic [COLOR_WIDTH-1:0]         window [FILTER_LENGTH];
  logic [CLOG2_FILTER_LENGTH-1:0] wr_ptr;
  logic [SUM_WIDTH-1:0]           sum;

  // The slot being overwritten is subtracted as the new sample is added, so the sum
  // always equals the total of the buffer; empty slots are zero and dilute the average.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < FILTER_LENGTH; i++) begin
        window[i] <= '0;
      end
      wr_ptr <= '0;
      sum    <= '0;
    end else if (wr_en) begin
      sum            <= sum + SUM_WIDTH'(diff) - SUM_WIDTH'(window[wr_ptr]);
      window[wr_ptr] <= diff;
      wr_ptr         <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
    end
  end

  assign avg = sum[SUM_WIDTH-1:CLOG2_FILTER_LENGTH];

endmodule

// File: rtl/delta_frame_filter.sv
// Absolute frame difference, optional moving average, then single-threshold or hysteresis
// binarisation; three-stage valid pipeline flushed by blanking or reset.
module delta_frame_filter
  import delta_pkg::*;
#(
  parameter int COLOR_WIDTH         = DEFAULT_COLOR_WIDTH,
  parameter int FILTER_LENGTH       = 16,
  parameter int CLOG2_FILTER_LENGTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   is_not_blank,
  input  logic [1:0]             mode,
  input  logic [COLOR_WIDTH-1:0] threshold_hi,
  input  logic [COLOR_WIDTH-1:0] threshold_lo,
  input  logic [COLOR_WIDTH-1:0] base_frame,
  input  logic [COLOR_WIDTH-1:0] curr_frame,
  output logic                   out_valid,
  output logic [COLOR_WIDTH-1:0] delta_frame,
  output logic [COLOR_WIDTH-1:0] avg_out
);

  logic                   flush;
  logic                   accept;
  logic                   v1;
  logic                   v2;
  logic                   det;
  logic [COLOR_WIDTH-1:0] diff;
  logic [COLOR_WIDTH-1:0] diff_d;
  logic [COLOR_WIDTH-1:0] avg;
  logic [COLOR_WIDTH-1:0] comp;

  assign flush  = reset || !is_not_blank;
  assign accept = in_valid && is_not_blank;

  always_ff @(posedge clk) begin
    if (flush) begin
      v1   <= 1'b0;
      diff <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        diff <= (curr_frame >= base_frame) ? curr_frame - base_frame
                                           : base_frame - curr_frame;
      end
    end
  end

  delta_avg_window #(
    .COLOR_WIDTH         (COLOR_WIDTH),
    .FILTER_LENGTH       (FILTER_LENGTH),
    .CLOG2_FILTER_LENGTH (CLOG2_FILTER_LENGTH)
  ) u_window (
    .clk   (clk),
    .reset (reset),
    .clear (!is_not_blank),
    .wr_en (v1),
    .diff  (diff),
    .avg   (avg)
  );

  always_ff @(posedge clk) begin
    if (flush) begin
      v2     <= 1'b0;
      diff_d <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        diff_d <= diff;
      end
    end
  end

  assign comp = mode[MODE_AVG_BIT] ? avg : diff_d;

  // In hysteresis mode the set test wins when the thresholds are inverted.
  always_ff @(posedge clk) begin
    if (flush) begin
      out_valid <= 1'b0;
      det       <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        if (!mode[MODE_HYST_BIT]) begin
          det <= (comp > threshold_hi);
        end else if (comp > threshold_hi) begin
          det <= 1'b1;
        end else if (comp < threshold_lo) begin
          det <= 1'b0;
        end
      end
    end
  end

  assign delta_frame = {COLOR_WIDTH{det}};
  assign avg_out     = avg;

endmodule
